// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers, driven by R-type funct codes.
// Optional build macro MULDIV_CANCEL_EN adds a cancel input that aborts an in-flight op.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULDIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata,
    output logic             dz
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  p_hi;     // partial product high half / division remainder
    logic [WIDTH-1:0]  p_lo;     // multiplier bits / dividend shifting into quotient
    logic [WIDTH-1:0]  mcand;    // multiplicand or divisor magnitude
    logic              neg_q;
    logic              neg_r;
    logic              is_div;
    logic              dz_pend;

    logic              sgn;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_sh;
    logic [WIDTH:0]    div_diff;
    logic [2*WIDTH-1:0] prod;
    logic              last;
    logic              cancel_hit;

    assign sgn      = (funct == F_MULT) || (funct == F_DIV);
    assign a_mag    = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag    = (sgn && b[WIDTH-1]) ? -b : b;
    assign mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign div_sh   = {p_hi, p_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mcand};
    assign prod     = {p_hi, p_lo};
    assign last     = (cnt == CW'(WIDTH-1));
    assign rdata    = (funct == F_MFHI) ? hi : lo;

`ifdef MULDIV_CANCEL_EN
    assign cancel_hit = cancel && busy;
`else
    assign cancel_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            mcand   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_div  <= 1'b0;
            dz_pend <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            if (cancel_hit) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (funct)
                                F_MTHI: hi <= a;
                                F_MTLO: lo <= a;
                                F_MULT, F_MULTU: begin
                                    state  <= MUL;
                                    busy   <= 1'b1;
                                    dz     <= 1'b0;
                                    cnt    <= '0;
                                    p_hi   <= '0;
                                    p_lo   <= b_mag;
                                    mcand  <= a_mag;
                                    neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                                    neg_r  <= 1'b0;
                                    is_div <= 1'b0;
                                    dz_pend <= 1'b0;
                                end
                                F_DIV, F_DIVU: begin
                                    // zero divisor skips the iterations entirely
                                    state  <= (b == '0) ? FIX : DIV;
                                    busy   <= 1'b1;
                                    dz     <= 1'b0;
                                    cnt    <= '0;
                                    p_hi   <= '0;
                                    p_lo   <= a_mag;
                                    mcand  <= b_mag;
                                    neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                                    neg_r  <= sgn && a[WIDTH-1];
                                    is_div <= 1'b1;
                                    dz_pend <= (b == '0);
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
                        cnt <= cnt + CW'(1);
                        if (last) state <= FIX;
                    end
                    DIV: begin
                        if (!div_diff[WIDTH]) begin
                            p_hi <= div_diff[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            p_hi <= div_sh[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CW'(1);
                        if (last) state <= FIX;
                    end
                    FIX: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (dz_pend) begin
                            dz <= 1'b1;
                        end else if (is_div) begin
                            hi <= neg_r ? -p_hi : p_hi;
                            lo <= neg_q ? -p_lo : p_lo;
                        end else begin
                            {hi, lo} <= neg_q ? -prod : prod;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
